dmem_responder: RTL and testbench

Word-addressed data-memory responder that terminates the pipeline's memory-stage load/store requests. Accepts one request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. The core sees the memory as a slave on its MEM stage and stalls while `req_ready` is low. The block holds the data array, the request capture registers, a latency counter and a three-state FSM.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory that answers one MEM-stage
// load/store request at a time over a valid/ready handshake. It responds a
// fixed LATENCY cycles after the accept cycle.
//
// Optional build macro: DMEM_BYTE_WRITE_EN
//   defined   - stores write only the byte lanes selected by req_be
//   undefined - req_be is ignored and stores write the full word
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready is high only in IDLE)
//   req_we                1 = store, 0 = load
//   req_addr              byte address (must be word aligned and below DEPTH words)
//   req_wdata, req_be     store data and byte-lane enables
//   resp_valid            single-cycle response strobe
//   resp_rdata            load data (0 for stores and errors)
//   resp_err              misaligned or out-of-range request
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CntLoad = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Captured request. The address is kept as word index plus error flag;
    // that is all the response and the store need.
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic          commit;
    logic [31:0]   wr_word;

    logic [31:0]   mem [DEPTH];

    assign accept  = req_valid && req_ready;
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; accept is already low while reset is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs, decoded from state and captured request only. Gating with
    // reset keeps a request interrupted in RESP from producing a response.
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        resp_valid = (state_q == StResp) && !reset;
        resp_err   = resp_valid && err_q;
        resp_rdata = '0;
        if (resp_valid && !err_q && !we_q) begin
            resp_rdata = mem[idx_q];
        end
    end

`ifdef DMEM_BYTE_WRITE_EN
    // Read-modify-write merge of the enabled lanes.
    always_comb begin
        wr_word = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                wr_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^be_q;
    assign wr_word   = wdata_q;
`endif

    // Store commits on the edge that ends the RESP cycle.
    assign commit = (state_q == StResp) && !reset && we_q && !err_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// load/store traffic compared against a word-array reference model. A second
// instance built with LATENCY=1 checks the shortest response timing.
module tb_dmem_responder;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        l1_valid, l1_ready, l1_we, l1_resp_valid, l1_resp_err;
    logic [31:0] l1_addr, l1_wdata, l1_rdata;
    logic [3:0]  l1_be;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (l1_valid),
        .req_ready  (l1_ready),
        .req_we     (l1_we),
        .req_addr   (l1_addr),
        .req_wdata  (l1_wdata),
        .req_be     (l1_be),
        .resp_valid (l1_resp_valid),
        .resp_rdata (l1_rdata),
        .resp_err   (l1_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns the expected response and applies any store.
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] exp_rdata,
                             output logic exp_err);
        int unsigned idx;
        logic [31:0] mask;
        idx       = addr / 4;
        exp_err   = (addr % 4 != 0) || (idx >= DEPTH);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (!we) begin
                exp_rdata = model_mem[idx];
            end else begin
`ifdef DMEM_BYTE_WRITE_EN
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
                mask = 32'hFFFF_FFFF;
`endif
                model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
            end
        end
    endtask

    // Called at a falling edge. Presents the request, follows it through the
    // whole latency window and returns at the falling edge of cycle LATENCY+1
    // with req_valid low, so back-to-back calls keep req_valid high.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          waited;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_txn(we, addr, wdata, be, exp_rdata, exp_err);
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge clk);
            check("busy_ready", 32'(req_ready), 32'd0);
            check("resp_valid", 32'(resp_valid), 32'(k == LATENCY));
            if (k == LATENCY) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
            end
            // Fields must be ignored while busy.
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_be    = 4'($urandom);
        end
        @(negedge clk);
        check("ready_again", 32'(req_ready), 32'd1);
        check("resp_valid_low", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
    endtask

    // Single request on the LATENCY=1 instance, called at a falling edge.
    task automatic l1_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        l1_valid = 1'b1;
        l1_we    = we;
        l1_addr  = addr;
        l1_wdata = wdata;
        l1_be    = 4'hF;
        check("l1_accept_ready", 32'(l1_ready), 32'd1);
        @(negedge clk);
        l1_valid = 1'b0;
        check("l1_resp_valid", 32'(l1_resp_valid), 32'd1);
        check("l1_busy_ready", 32'(l1_ready), 32'd0);
        check("l1_rdata", l1_rdata, exp_rdata);
        check("l1_err", 32'(l1_resp_err), 32'(exp_err));
        @(negedge clk);
        check("l1_ready_again", 32'(l1_ready), 32'd1);
        check("l1_resp_valid_low", 32'(l1_resp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        l1_valid  = 1'b0;
        l1_we     = 1'b0;
        l1_addr   = '0;
        l1_wdata  = '0;
        l1_be     = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Give every word a known value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF);
        end

        // Basic store / load.
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'hF);

        // Error cases; the bad store must not touch the array.
        do_req(1'b0, 32'h102, 32'h0, 4'hF);
        do_req(1'b0, 32'h100, 32'h0, 4'hF);
        do_req(1'b1, 32'h102, 32'hAA, 4'hF);
        do_req(1'b0, 32'h100, 32'h0, 4'hF);
        do_req(1'b0, 32'h0FC, 32'h0, 4'hF);
        do_req(1'b0, 32'h0FC, 32'h0, 4'hF);
        do_req(1'b0, 32'h104, 32'h0, 4'hF);
        do_req(1'b0, 32'h100, 32'h0, 4'hF);

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'(i * 4), 32'h0, 4'hF);
        end

        // Reset in the middle of a store drops it.
        do_req(1'b1, 32'h20, 32'h0, 4'hF);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55;
        req_be    = 4'hF;
        check("mid_accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
            check("mid_rst_ready", 32'(req_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("mid_post_rst_ready", 32'(req_ready), 32'd1);
        check("mid_post_rst_resp", 32'(resp_valid), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);

        // Byte lanes.
        do_req(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        do_req(1'b1, 32'h8, 32'h0000_1234, 4'b0011);
        do_req(1'b0, 32'h8, 32'h0, 4'hF);
        do_req(1'b1, 32'h8, 32'h5555_5555, 4'b0000);
        do_req(1'b0, 32'h8, 32'h0, 4'hF);

        // Random traffic.
        repeat (300) begin
            a = 32'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = 2'b00;
            end
            do_req(1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end
        end

        // LATENCY=1 instance.
        l1_req(1'b1, 32'h4, 32'h1234_5678, 32'h0, 1'b0);
        l1_req(1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);
        l1_req(1'b0, 32'h3, 32'h0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
